// File: rtl/code_loader.sv
// -----------------------------------------------------------------------------
// code_loader
//
// Purpose:
//   Assembles 64-bit instructions from pairs of 32-bit host words (high word
//   first, then low word) and writes them sequentially into a code memory
//   starting at address 0. A load is started by a one-cycle start pulse and
//   finishes when the low word of an instruction arrives flagged as last.
//   A last flag on a high word (odd word count) or an attempt to exceed DEPTH
//   instructions aborts the load.
//
// Ports:
//   clk       - sole clock, all logic on its rising edge
//   rst       - synchronous active-high reset (highest priority)
//   start     - one-cycle pulse, begins a new load at address 0
//   in_data   - 32-bit program word from the host
//   in_valid  - in_data is valid
//   in_ready  - loader accepts in_data this cycle
//   in_last   - in_data is the final word of the program
//   wr_addr   - code memory write address (held when wr_en=0)
//   wr_data   - code memory write data (held when wr_en=0)
//   wr_en     - one-cycle write strobe per completed instruction
//   prog_len  - instructions written in the current or last load
//   done      - level, load completed without error
//   error     - level, load aborted (odd word count or overflow)
// -----------------------------------------------------------------------------
module code_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH:0]   prog_len,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  // Instruction-count limit expressed in prog_len's width.
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                  state_r,    state_next_s;
  logic [31:0]             held_r,     held_next_s;
  logic                    wr_en_r,    wr_en_next_s;
  logic [ADDR_WIDTH-1:0]   wr_addr_r,  wr_addr_next_s;
  logic [DATA_WIDTH-1:0]   wr_data_r,  wr_data_next_s;
  logic [ADDR_WIDTH:0]     prog_len_r, prog_len_next_s;
  logic                    done_r,     done_next_s;
  logic                    error_r,    error_next_s;
  logic                    in_ready_s;
  logic                    handshake_s;

  // Ready only while collecting words; start and rst steal the cycle so a
  // word presented alongside them is never consumed.
  assign in_ready_s  = ((state_r == HI) || (state_r == LO)) && !start && !rst;
  assign handshake_s = in_valid && in_ready_s;

  // Next-state and datapath decisions for every register.
  always_comb begin
    state_next_s    = state_r;
    held_next_s     = held_r;
    wr_en_next_s    = 1'b0;
    wr_addr_next_s  = wr_addr_r;
    wr_data_next_s  = wr_data_r;
    prog_len_next_s = prog_len_r;

    if (start) begin
      state_next_s    = HI;
      held_next_s     = 32'd0;
      prog_len_next_s = {(ADDR_WIDTH + 1){1'b0}};
    end else if (handshake_s) begin
      case (state_r)
        HI: begin
          // A last flag here means an odd word count; a full program means
          // overflow. Either way the word is dropped.
          if (in_last || (prog_len_r == DEPTH_L)) begin
            state_next_s = ERR;
          end else begin
            held_next_s  = in_data;
            state_next_s = LO;
          end
        end
        LO: begin
          wr_en_next_s    = 1'b1;
          wr_addr_next_s  = prog_len_r[ADDR_WIDTH-1:0];
          wr_data_next_s  = DATA_WIDTH'({held_r, in_data});
          prog_len_next_s = prog_len_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
          if (in_last) begin
            state_next_s = DONE;
          end else begin
            state_next_s = HI;
          end
        end
        default: begin
          state_next_s = state_r;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end

    done_next_s  = (state_next_s == DONE);
    error_next_s = (state_next_s == ERR);
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      held_r     <= 32'd0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= {ADDR_WIDTH{1'b0}};
      wr_data_r  <= {DATA_WIDTH{1'b0}};
      prog_len_r <= {(ADDR_WIDTH + 1){1'b0}};
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      held_r     <= held_next_s;
      wr_en_r    <= wr_en_next_s;
      wr_addr_r  <= wr_addr_next_s;
      wr_data_r  <= wr_data_next_s;
      prog_len_r <= prog_len_next_s;
      done_r     <= done_next_s;
      error_r    <= error_next_s;
    end
  end

  assign in_ready = in_ready_s;
  assign wr_en    = wr_en_r;
  assign wr_addr  = wr_addr_r;
  assign wr_data  = wr_data_r;
  assign prog_len = prog_len_r;
  assign done     = done_r;
  assign error    = error_r;

endmodule

// File: doc/code_loader.md
CODE_LOADER -- requirements
Module: code_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, code memory address width.
REQ-002 Parameter DATA_WIDTH, default 64, instruction width; fixed at 2x32-bit input words.
REQ-003 Parameter DEPTH, default 256, maximum instruction count accepted per program.
REQ-004 clk  input  1  sole clock; all logic on posedge clk.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 start  input  1  single-cycle pulse; begins a new program load at address 0.
REQ-007 in_data  input  32  program word from host.
REQ-008 in_valid  input  1  in_data is valid.
REQ-009 in_ready  output  1  loader accepts in_data this cycle.
REQ-010 in_last  input  1  in_data is the final word of the program.
REQ-011 wr_addr  output  ADDR_WIDTH  code memory write address.
REQ-012 wr_data  output  DATA_WIDTH  code memory write data.
REQ-013 wr_en  output  1  code memory write strobe, one cycle per instruction.
REQ-014 prog_len  output  ADDR_WIDTH+1  instructions written in the current or last load.
REQ-015 done  output  1  level; load completed without error.
REQ-016 error  output  1  level; load aborted (odd word count or overflow).

Function
REQ-017 States: IDLE, HI (await high word), LO (await low word), DONE, ERR.
REQ-018 Word handshake occurs on a cycle with in_valid=1 and in_ready=1.
REQ-019 in_ready is 1 in HI and LO only; 0 in IDLE, DONE, ERR.
REQ-020 start in any state: prog_len<=0, held word discarded, done<=0, error<=0, state<=HI.
REQ-021 HI handshake, prog_len<DEPTH, in_last=0: store in_data as bits [63:32], go to LO.
REQ-022 HI handshake with in_last=1: word dropped, go to ERR (odd word count).
REQ-023 HI handshake with prog_len==DEPTH: word dropped, go to ERR (overflow).
REQ-024 LO handshake: next cycle wr_en=1, wr_data={held word, in_data}, wr_addr=prog_len value before increment; prog_len increments by 1 on that same cycle.
REQ-025 LO handshake with in_last=0 returns to HI; with in_last=1 goes to DONE.
REQ-026 Write latency: exactly one cycle from low-word handshake to wr_en; no other cycle asserts wr_en.
REQ-027 wr_addr and wr_data hold their last values when wr_en=0.
REQ-028 done=1 exactly while in DONE; error=1 exactly while in ERR.
REQ-029 Back-to-back handshakes every cycle are sustained: one instruction written per two cycles, no bubbles required.
REQ-030 in_valid=0 in HI or LO: state and held word unchanged.
REQ-031 start and handshake on the same cycle: start wins; the word is not accepted (in_ready forced 0 that cycle).
REQ-032 Only instructions fully written before an error count in prog_len; prog_len frozen in DONE and ERR.
REQ-033 wr_addr is the low ADDR_WIDTH bits of prog_len; DEPTH <= 2**ADDR_WIDTH.

Reset
REQ-034 rst=1: state IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, prog_len=0, done=0, error=0.
REQ-035 rst has priority over start and any handshake on the same cycle.
REQ-036 rst mid-load abandons the held word; no wr_en follows the reset cycle.

Verification
REQ-037 start; words 0x00280000, 0x0000000C (last) -> one cycle after second handshake wr_en=1, wr_addr=0, wr_data=0x002800000000000C; done=1, prog_len=1.
REQ-038 start; 32 words continuous valid, last on word 32 -> 16 writes at addresses 0..15, one every 2 cycles; done=1, prog_len=16.
REQ-039 start; 3 words, in_last on word 3 -> one write at address 0; error=1, done=0, prog_len=1, in_ready=0.
REQ-040 start; 514 words without in_last -> 256 writes (addresses 0..255); word 513 dropped; error=1, prog_len=256.
REQ-041 start; high word accepted, rst asserted -> no wr_en, all outputs at reset values; subsequent start plus 2 words writes address 0.
REQ-042 start; 1 high word accepted, start again, then 2 words (last) -> single write at address 0 containing only the post-restart words; done=1, prog_len=1.
